// File: rtl/dsp_mac_pipe.sv
// Three-stage multiply-accumulate slice: pre-adder/multiplier, post-adder with
// per-sample OPMODE, valid/ready flow control with a global stall, and optional saturation.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 48,
    parameter int SATURATE = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [P_WIDTH-1:0]         C,
    input  logic [P_WIDTH-1:0]         PCIN,
    input  logic                       CARRYIN,
    input  logic [7:0]                 OPMODE,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [A_WIDTH+B_WIDTH-1:0] M,
    output logic [P_WIDTH-1:0]         P,
    output logic [P_WIDTH-1:0]         PCOUT,
    output logic                       CARRYOUT,
    output logic                       OVF
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH;

    logic adv;
    logic out_valid_reg;

    logic signed [A_WIDTH-1:0] a1_reg;
    logic signed [B_WIDTH-1:0] b1_reg;
    logic signed [B_WIDTH-1:0] d1_reg;
    logic [P_WIDTH-1:0]        c1_reg;
    logic                      cin1_reg;
    logic [7:0]                op1_reg;
    logic                      v1_reg;

    logic signed [B_WIDTH-1:0] pa;
    logic signed [B_WIDTH-1:0] mb;
    logic signed [M_WIDTH-1:0] prod;

    logic signed [M_WIDTH-1:0] m2_reg;
    logic signed [A_WIDTH-1:0] a2_reg;
    logic [P_WIDTH-1:0]        c2_reg;
    logic                      cin2_reg;
    logic [4:0]                op2_reg;
    logic                      v2_reg;

    logic [P_WIDTH-1:0]        x_p;
    logic [P_WIDTH-1:0]        z_p;
    logic [P_WIDTH:0]          r_u;
    logic [P_WIDTH+1:0]        r_s;
    logic [P_WIDTH+1:0]        x_s;
    logic [P_WIDTH+1:0]        z_s;
    logic [P_WIDTH+1:0]        cin_s;
    logic                      ovf_next;
    logic [P_WIDTH-1:0]        p_next;

    logic [P_WIDTH-1:0]        p_reg;
    logic [M_WIDTH-1:0]        m_reg;
    logic                      carry_reg;
    logic                      ovf_reg;
    logic                      unused_bits;

    // A full output register that is not being taken freezes the whole pipe.
    assign adv      = !out_valid_reg || OUT_READY;
    assign IN_READY = adv;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a1_reg   <= '0;
            b1_reg   <= '0;
            d1_reg   <= '0;
            c1_reg   <= '0;
            cin1_reg <= 1'b0;
            op1_reg  <= '0;
            v1_reg   <= 1'b0;
        end else if (adv) begin
            a1_reg   <= A;
            b1_reg   <= B;
            d1_reg   <= D;
            c1_reg   <= C;
            cin1_reg <= CARRYIN;
            op1_reg  <= OPMODE;
            v1_reg   <= IN_VALID;
        end
    end

    always_comb begin
        pa   = op1_reg[6] ? d1_reg - b1_reg : d1_reg + b1_reg;
        mb   = op1_reg[4] ? pa : b1_reg;
        prod = $signed({{B_WIDTH{a1_reg[A_WIDTH-1]}}, a1_reg})
             * $signed({{A_WIDTH{mb[B_WIDTH-1]}}, mb});
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            m2_reg   <= '0;
            a2_reg   <= '0;
            c2_reg   <= '0;
            cin2_reg <= 1'b0;
            op2_reg  <= '0;
            v2_reg   <= 1'b0;
        end else if (adv) begin
            m2_reg   <= prod;
            a2_reg   <= a1_reg;
            c2_reg   <= c1_reg;
            cin2_reg <= cin1_reg;
            op2_reg  <= {op1_reg[7], op1_reg[3:0]};
            v2_reg   <= v1_reg;
        end
    end

    // r_u gives the unsigned carry/borrow; r_s keeps two guard bits for overflow and true sign.
    always_comb begin
        case (op2_reg[1:0])
            2'd0:    x_p = '0;
            2'd1:    x_p = {{(P_WIDTH-M_WIDTH){m2_reg[M_WIDTH-1]}}, m2_reg};
            2'd2:    x_p = {{(P_WIDTH-A_WIDTH){a2_reg[A_WIDTH-1]}}, a2_reg};
            default: x_p = p_reg;
        endcase
        case (op2_reg[3:2])
            2'd0:    z_p = '0;
            2'd1:    z_p = PCIN;
            2'd2:    z_p = p_reg;
            default: z_p = c2_reg;
        endcase
        x_s   = {{2{x_p[P_WIDTH-1]}}, x_p};
        z_s   = {{2{z_p[P_WIDTH-1]}}, z_p};
        cin_s = {{(P_WIDTH+1){1'b0}}, cin2_reg};
        if (op2_reg[4]) begin
            r_u = {1'b0, z_p} - ({1'b0, x_p} + {{P_WIDTH{1'b0}}, cin2_reg});
            r_s = z_s - (x_s + cin_s);
        end else begin
            r_u = {1'b0, z_p} + {1'b0, x_p} + {{P_WIDTH{1'b0}}, cin2_reg};
            r_s = z_s + x_s + cin_s;
        end
        ovf_next = !((r_s[P_WIDTH+1] == r_s[P_WIDTH]) && (r_s[P_WIDTH] == r_s[P_WIDTH-1]));
        p_next   = r_s[P_WIDTH-1:0];
        if ((SATURATE != 0) && ovf_next) begin
            p_next = r_s[P_WIDTH+1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    // Only valid samples touch P, so bubbles never disturb an accumulation.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_reg <= 1'b0;
            p_reg         <= '0;
            m_reg         <= '0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                p_reg     <= p_next;
                m_reg     <= m2_reg;
                carry_reg <= r_u[P_WIDTH];
                ovf_reg   <= ovf_next;
            end
        end
    end

    assign unused_bits = ^{op1_reg[5], r_u[P_WIDTH-1:0]};

    assign OUT_VALID = out_valid_reg;
    assign M         = m_reg;
    assign P         = p_reg;
    assign PCOUT     = p_reg;
    assign CARRYOUT  = carry_reg;
    assign OVF       = ovf_reg;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a wrapping and a saturating instance share stimulus;
// expected results are queued at acceptance and compared when each result is taken.
module tb_dsp_mac_pipe;
    localparam longint PMAX   = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint PMIN   = -64'sh0000_8000_0000_0000;
    localparam longint MASK48 = 64'sh0000_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0, pcin = '0;
    logic        cin = 1'b0;
    logic [7:0]  op = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, cout, ovf;
    logic [35:0] m;
    logic [47:0] p, pcout;
    logic        in_ready_s, out_valid_s, cout_s, ovf_s;
    logic [35:0] m_s;
    logic [47:0] p_s, pcout_s;

    typedef struct {
        logic [35:0] m;
        logic [47:0] p0, p1;
        logic        co0, co1, ov0, ov1;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              mon_e;
    logic [47:0]       obs_q[$];
    logic signed [47:0] model_p[2];
    int checks = 0;
    int errors = 0;
    logic stream_done;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.SATURATE(0)) dut (
        .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .CARRYIN(cin), .OPMODE(op), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .M(m), .P(p), .PCOUT(pcout),
        .CARRYOUT(cout), .OVF(ovf)
    );

    dsp_mac_pipe #(.SATURATE(1)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .CARRYIN(cin), .OPMODE(op), .IN_VALID(in_valid), .IN_READY(in_ready_s),
        .OUT_VALID(out_valid_s), .OUT_READY(out_ready), .M(m_s), .P(p_s), .PCOUT(pcout_s),
        .CARRYOUT(cout_s), .OVF(ovf_s)
    );

    // Reference model: index 0 wraps, index 1 saturates.
    task automatic model_push(input logic signed [17:0] ta, tb_, td, input logic signed [47:0] tc,
                              input logic tcin, input logic [7:0] top);
        logic signed [17:0] pa, mb;
        longint prod, xv, zv, tv, zu, xu;
        logic [47:0] pr;
        logic ov, co;
        exp_t e;
        pa = top[6] ? td - tb_ : td + tb_;
        mb = top[4] ? pa : tb_;
        prod = longint'(ta) * longint'(mb);
        e.m = prod[35:0];
        for (int k = 0; k < 2; k++) begin
            case (top[1:0])
                2'd0: xv = 0;
                2'd1: xv = prod;
                2'd2: xv = longint'(ta);
                default: xv = longint'(model_p[k]);
            endcase
            case (top[3:2])
                2'd0: zv = 0;
                2'd1: zv = longint'($signed(pcin));
                2'd2: zv = longint'(model_p[k]);
                default: zv = longint'(tc);
            endcase
            tv = top[7] ? zv - (xv + longint'(tcin)) : zv + xv + longint'(tcin);
            ov = (tv > PMAX) || (tv < PMIN);
            pr = tv[47:0];
            if (k == 1 && ov) pr = (tv < 0) ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
            zu = zv & MASK48;
            xu = xv & MASK48;
            if (top[7]) co = (zu < xu + longint'(tcin));
            else        co = (((zu + xu + longint'(tcin)) >>> 48) & 1) != 0;
            model_p[k] = pr;
            if (k == 0) begin e.p0 = pr; e.co0 = co; e.ov0 = ov; end
            else        begin e.p1 = pr; e.co1 = co; e.ov1 = ov; end
        end
        sb_q.push_back(e);
    endtask

    // A result is consumed at the next edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got p=%h with empty scoreboard", p);
            end else begin
                mon_e = sb_q.pop_front();
                obs_q.push_back(p);
                if (m !== mon_e.m || p !== mon_e.p0 || cout !== mon_e.co0 || ovf !== mon_e.ov0 || pcout !== p) begin
                    errors++;
                    $display("FAIL wrap_result got m=%h p=%h pcout=%h co=%b ovf=%b exp m=%h p=%h co=%b ovf=%b",
                             m, p, pcout, cout, ovf, mon_e.m, mon_e.p0, mon_e.co0, mon_e.ov0);
                end
                checks++;
                if (!out_valid_s || m_s !== mon_e.m || p_s !== mon_e.p1 || cout_s !== mon_e.co1 || ovf_s !== mon_e.ov1) begin
                    errors++;
                    $display("FAIL sat_result got v=%b m=%h p=%h co=%b ovf=%b exp m=%h p=%h co=%b ovf=%b",
                             out_valid_s, m_s, p_s, cout_s, ovf_s, mon_e.m, mon_e.p1, mon_e.co1, mon_e.ov1);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        obs_q.delete();
        model_p[0] = '0;
        model_p[1] = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic drive_sample(input logic signed [17:0] ta, tb_, td, input logic signed [47:0] tc,
                                input logic tcin, input logic [7:0] top);
        int n;
        logic acc;
        a = ta; b = tb_; d = td; c = tc; cin = tcin; op = top;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready && rst_n;
            if (acc) model_push(ta, tb_, td, tc, tcin, top);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got no accept in %0d cycles exp accept", n);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d results pending exp 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== '0 || m !== '0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b p=%h m=%h co=%b ovf=%b rdy=%b exp 0 0 0 0 0 1",
                     out_valid, p, m, cout, ovf, in_ready);
        end
        checks++;
        if (out_valid_s !== 1'b0 || p_s !== '0) begin
            errors++;
            $display("FAIL reset_state_sat got v=%b p=%h exp 0 0", out_valid_s, p_s);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int n;
        pcin = 48'd10;
        drive_sample(18'sd3, 18'sd4, 18'sd0, 48'sd0, 1'b0, 8'h05);
        wait_valid(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", n); end
        checks++;
        if (m !== 36'd12 || p !== 48'd22 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_value got m=%0d p=%0d co=%b exp m=12 p=22 co=0", m, p, cout);
        end
        drain();
        pcin = '0;
    endtask

    task automatic test_pre_subtract();
        int n;
        logic signed [35:0] em;
        logic signed [47:0] ep;
        em = -36'sd14;
        ep = -48'sd14;
        drive_sample(-18'sd2, 18'sd3, 18'sd10, 48'sd0, 1'b0, 8'h51);
        wait_valid(n);
        checks++;
        if (m !== em || p !== ep) begin
            errors++;
            $display("FAIL pre_subtract got m=%h p=%h exp m=%h p=%h", m, p, em, ep);
        end
        drain();
    endtask

    task automatic test_accumulate();
        logic [47:0] ev;
        do_reset();
        for (int i = 0; i < 2; i++) drive_sample(18'sd2, 18'sd5, 18'sd0, 48'sd0, 1'b0, 8'h09);
        drain();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (p !== 48'd20 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bubble_hold got p=%0d v=%b exp p=20 v=0", p, out_valid);
            end
        end
        for (int i = 0; i < 3; i++) drive_sample(18'sd2, 18'sd5, 18'sd0, 48'sd0, 1'b0, 8'h09);
        drain();
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL accum_count got %0d exp 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                ev = 48'(10 * (i + 1));
                checks++;
                if (obs_q[i] !== ev) begin
                    errors++;
                    $display("FAIL accum_seq[%0d] got %0d exp %0d", i, obs_q[i], ev);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [47:0] held;
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive_sample(18'(i + 1), 18'(7 * (i + 2)), 18'sd0, 48'sd0, 1'b0, 8'h09);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
                out_ready = 1'b0;
                held = p;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || p !== held) begin
                        errors++;
                        $display("FAIL stall got rdy=%b v=%b p=%h exp rdy=0 v=1 p=%h", in_ready, out_valid, p, held);
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count got %0d exp 4", obs_q.size());
        end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        drive_sample(18'sd1, 18'sd0, 18'sd0, 48'sh7FFF_FFFF_FFFF, 1'b0, 8'h0E);
        wait_valid(n);
        checks++;
        if (p !== 48'h8000_0000_0000 || ovf !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("FAIL wrap_overflow got p=%h ovf=%b co=%b exp p=800000000000 ovf=1 co=0", p, ovf, cout);
        end
        checks++;
        if (p_s !== 48'h7FFF_FFFF_FFFF || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_overflow got p=%h ovf=%b exp p=7fffffffffff ovf=1", p_s, ovf_s);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic signed [47:0] rc;
        pcin = {16'($urandom), 32'($urandom)};
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 2))
                        0: rc = 48'sh7FFF_FFFF_FFFF;
                        1: rc = 48'sh8000_0000_0000;
                        default: rc = {16'($urandom), 32'($urandom)};
                    endcase
                    drive_sample(18'($urandom), 18'($urandom), 18'($urandom), rc,
                                 1'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        pcin = '0;
    endtask

    task automatic test_reset_midstream();
        int n;
        drive_sample(18'sd5, 18'sd6, 18'sd0, 48'sd0, 1'b0, 8'h01);
        drive_sample(18'sd7, 18'sd8, 18'sd0, 48'sd0, 1'b0, 8'h01);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        obs_q.delete();
        model_p[0] = '0;
        model_p[1] = '0;
        checks++;
        if (out_valid !== 1'b0 || p !== '0 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset got v=%b p=%h vs=%b exp 0 0 0", out_valid, p, out_valid_s);
        end
        drive_sample(18'sd3, 18'sd4, 18'sd0, 48'sd0, 1'b0, 8'h01);
        wait_valid(n);
        checks++;
        if (n != 3 || p !== 48'd12) begin
            errors++;
            $display("FAIL post_reset got latency=%0d p=%0d exp latency=3 p=12", n, p);
        end
        drain();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL post_reset_count got %0d exp 1", obs_q.size());
        end
    endtask

    initial begin
        model_p[0] = '0;
        model_p[1] = '0;
        test_reset();
        test_basic();
        test_pre_subtract();
        test_accumulate();
        test_back_pressure();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised, fully pipelined multiply-accumulate slice. It is the successor to the fixed 18x18/48-bit DSP slice. It adds configurable operand and accumulator widths, a per-sample OPMODE that travels with its data, a valid/ready handshake with global stall, optional saturation with an overflow flag, and a carry-out. It sits in datapath chains and cascades through PCIN/PCOUT.

Parameters:
A_WIDTH, 18, signed width of A.
B_WIDTH, 18, signed width of B and D. The pre-adder result is also B_WIDTH bits.
P_WIDTH, 48, width of C, PCIN, P and PCOUT. Must be >= A_WIDTH+B_WIDTH+1.
SATURATE, 0, 1 = clamp the post-adder result on signed overflow. 0 = wrap.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  synchronous, active-low reset.
A  in  A_WIDTH  signed multiplier operand.
B  in  B_WIDTH  signed pre-adder/multiplier operand.
D  in  B_WIDTH  signed pre-adder operand.
C  in  P_WIDTH  signed post-adder operand.
PCIN  in  P_WIDTH  cascade input from the previous slice's PCOUT.
CARRYIN  in  1  post-adder carry/borrow input.
OPMODE  in  8  per-sample mode, captured together with the data.
IN_VALID  in  1  input sample valid.
IN_READY  out  1  slice accepts a sample this cycle.
OUT_VALID  out  1  P/M/CARRYOUT/OVF hold a valid result.
OUT_READY  in  1  downstream accepts the result.
M  out  A_WIDTH+B_WIDTH  registered product.
P  out  P_WIDTH  registered post-adder result.
PCOUT  out  P_WIDTH  equals P.
CARRYOUT  out  1  carry/borrow out of the post-adder.
OVF  out  1  signed overflow of the post-adder, sticky per result (not cumulative).

Behaviour:
- Reset (RST_N=0 at an edge): all stage valids cleared. M=0, P=0, CARRYOUT=0, OVF=0, OUT_VALID=0. IN_READY is combinational, so it reads 1 while OUT_VALID=0. Reset mid-operation discards all in-flight samples.
- Advance enable: adv = !OUT_VALID || OUT_READY. IN_READY = adv. A sample is accepted when IN_VALID && adv.
- Stage 1 (on adv): register A, B, D, C, CARRYIN, OPMODE and v1 <= IN_VALID.
- Stage 2 (on adv): compute and register M and v2 <= v1.
  - Pre-adder: pa = OPMODE[6] ? D - B : D + B, truncated to B_WIDTH (wraps).
  - Multiplier operand: mb = OPMODE[4] ? pa : B.
  - M = signed A * mb, full A_WIDTH+B_WIDTH bits.
  - C, CARRYIN and OPMODE move forward with the sample.
- Stage 3 (on adv && v2 only): P, CARRYOUT and OVF load. On adv && !v2, P holds, so bubbles never disturb the accumulator.
  - Output valid: OUT_VALID <= v2 on adv. OUT_VALID holds while !adv.
  - X (OPMODE[1:0]): 0 = zero; 1 = M sign-extended; 2 = A sign-extended; 3 = P (current register).
  - Z (OPMODE[3:2]): 0 = zero; 1 = PCIN; 2 = P; 3 = stage-2 C.
  - Arithmetic is computed at P_WIDTH+1 bits:
    - OPMODE[7]=0: r = Z + X + CIN.
    - OPMODE[7]=1: r = Z - (X + CIN).
  - CARRYOUT = r[P_WIDTH] (unsigned carry, or borrow when subtracting).
  - OVF = signed overflow of the P_WIDTH-bit result.
  - SATURATE=1 and OVF: P = max positive when the true sign is positive, else min negative.
  - SATURATE=0: P = r[P_WIDTH-1:0].
- OPMODE[5] is reserved; it is ignored.
- Latency: an accepted sample's result appears with OUT_VALID exactly 3 edges after acceptance when there is no stall. Throughput is 1 sample/cycle.
- Stall (OUT_VALID && !OUT_READY): every register holds, IN_READY=0, and outputs are stable until accepted.
- Accumulation: Z=P uses the result of the previous valid sample, independent of bubbles or stalls between them.
- Simultaneous output accept and input accept in the same cycle is legal and lossless.

Test Plan:
- Reset, then A=3, B=4, D=0, OPMODE=0x05 (X=M, Z=PCIN), PCIN=10 -> OUT_VALID on the 3rd edge after accept; M=12, P=22, CARRYOUT=0.
- Pre-subtract: D=10, B=3, A=-2, OPMODE=0x51 (preadd on, subtract, X=M, Z=0) -> M=-14, P=-14 (all ones above bit 4).
- Accumulate: 5 samples A=2, B=5 with OPMODE=0x09 (X=M, Z=P), bubbles inserted between samples 2 and 3 -> P sequence 10, 20, 30, 40, 50; P unchanged during bubbles.
- Back-pressure: stream 4 samples with OUT_READY=0 for 5 cycles after the first result -> IN_READY=0 during the stall, no result lost or duplicated, results in order.
- Saturation (SATURATE=1, P_WIDTH=48): Z=C=2^47-1, X=A=1, OPMODE=0x0E -> P=2^47-1, OVF=1. With SATURATE=0 -> P=-2^47, OVF=1.
- Reset mid-stream with 2 samples in flight -> OUT_VALID=0 and P=0 after the reset edge; the next sample's result appears 3 edges after its acceptance.
